// File: rtl/nibble_serial_add_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl_if
// Brief    : Requester handshake and 4-bit adder-slice bus for the sequencer.
//            NIBBLE_SERIAL_ADD_OVF_EN adds the ovf signal.
// Revision : 1.0 - initial release
// ============================================================================
interface nibble_serial_add_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    logic             ovf;
`endif
    logic [3:0]       slice_a;
    logic [3:0]       slice_b;
    logic             slice_cin;
    logic [3:0]       slice_sum;
    logic             slice_cout;

    modport slave (
        input  start, a, b, cin, slice_sum, slice_cout,
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        output ovf,
`endif
        output busy, done, sum, cout, slice_a, slice_b, slice_cin
    );

    modport master (
        output start, a, b, cin, slice_sum, slice_cout,
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
        input  ovf,
`endif
        input  busy, done, sum, cout, slice_a, slice_b, slice_cin
    );
endinterface
`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_add_ctrl
// Brief    : Adds two WIDTH-bit operands one nibble per clock through a shared
//            external 4-bit adder slice. NIBBLE_SERIAL_ADD_OVF_EN adds ovf.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_add_ctrl #(
    parameter int WIDTH = 16
) (
    input  wire logic           clk,
    input  wire logic           rst_n,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int NIB    = WIDTH / 4;
    localparam int c_IDXW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [c_IDXW-1:0] c_LAST = c_IDXW'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [WIDTH-1:0]    r_sum;
    logic [c_IDXW-1:0]   r_idx;
    logic                r_carry;
    logic                r_cout;
    logic                r_busy;
    logic                r_done;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    logic                r_ovf;
`endif
    logic [3:0]          w_slice_a;
    logic [3:0]          w_slice_b;
    logic                w_slice_cin;
    logic                w_accept;
    logic                w_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_slice_a   = 4'd0;
        w_slice_b   = 4'd0;
        w_slice_cin = 1'b0;
        w_accept    = 1'b0;
        w_last      = (r_idx == c_LAST);
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_slice_a   = r_a[4*r_idx +: 4];
                w_slice_b   = r_b[4*r_idx +: 4];
                w_slice_cin = r_carry;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_a     <= bus.a;
                r_b     <= bus.b;
                r_carry <= bus.cin;
                r_idx   <= '0;
                r_sum   <= '0;
                r_cout  <= 1'b0;
                r_busy  <= 1'b1;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
                r_ovf   <= 1'b0;
`endif
            end
            if (r_state == S_RUN) begin
                r_sum[4*r_idx +: 4] <= bus.slice_sum;
                r_carry             <= bus.slice_cout;
                if (w_last) begin
                    r_cout <= bus.slice_cout;
                    r_done <= 1'b1;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
                    // Sign of the result differs from both operand signs.
                    r_ovf  <= r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ bus.slice_sum[3] ^ bus.slice_cout;
`endif
                end else begin
                    r_idx <= r_idx + c_IDXW'(1);
                end
            end
            if (r_state == S_DONE) begin
                r_done <= 1'b0;
                r_busy <= 1'b0;
            end
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.slice_a   = w_slice_a;
    assign bus.slice_b   = w_slice_b;
    assign bus.slice_cin = w_slice_cin;
`ifdef NIBBLE_SERIAL_ADD_OVF_EN
    assign bus.ovf       = r_ovf;
`endif

endmodule
`default_nettype wire
